// File: rtl/seq_mul_pkg.sv
// Shared types and width defaults for the sequential signed multiplier.
// Consumers build with or without EARLY_TERM_EN; nothing here depends on it.
package seq_mul_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_PAIRS = DEF_WIDTH / 2;
  localparam int DEF_PW    = 2 * DEF_WIDTH;
  localparam int DEF_SW    = DEF_WIDTH + 2;
  localparam int DEF_KW    = $clog2(DEF_PAIRS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_mul_acc.sv
// Shift-and-add accumulator: adds sext(lay_sum) << 2k per enabled cycle.
// Two's-complement wrap at 2*WIDTH bits is the intended arithmetic.
module seq_mul_acc
  import seq_mul_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clr,
  input  logic                          en,
  input  logic [$clog2(WIDTH/2)-1:0]    k,
  input  logic [WIDTH+1:0]              lay_sum,
  output logic [2*WIDTH-1:0]            acc
);

  localparam int PW = 2 * WIDTH;
  localparam int SW = WIDTH + 2;

  logic [PW-1:0] sum_ext;
  logic [PW-1:0] term;

  assign sum_ext = {{(PW-SW){lay_sum[SW-1]}}, lay_sum};
  assign term    = sum_ext << {k, 1'b0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + term;
    end
  end

endmodule

// File: rtl/seq_mul_signed16_ctrl.sv
// Radix-4 sequential signed multiply controller driving an external 16x2 layer.
// Optional EARLY_TERM_EN ends RUN once the remaining multiplier bits are zero.
module seq_mul_signed16_ctrl
  import seq_mul_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  output logic [WIDTH-1:0]     lay_a,
  output logic                 lay_b_low,
  output logic                 lay_b_high,
  output logic                 lay_cin,
  input  logic [WIDTH+1:0]     lay_sum,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_p,
  output logic                 busy
);

  localparam int PAIRS = WIDTH / 2;
  localparam int KW    = $clog2(PAIRS);

  state_t            state;
  state_t            state_nx;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic [KW-1:0]     k;
  logic [2*WIDTH-1:0] acc;
  logic              start;
  logic              skip;
  logic              step;
  logic              last;

  assign start = (state == IDLE) && in_valid;
  assign last  = (k == KW'(PAIRS - 1));

`ifdef EARLY_TERM_EN
  assign skip = (b_q == '0);
`else
  assign skip = 1'b0;
`endif

  assign step = (state == RUN) && !skip;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (in_valid) state_nx = RUN;
      RUN:  if (skip || last) state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // b_q shifts logically so the live digit always sits in bits [1:0]
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      k   <= '0;
    end else if (start) begin
      a_q <= in_a;
      b_q <= in_b;
      k   <= '0;
    end else if (step) begin
      b_q <= b_q >> 2;
      k   <= k + 1'b1;
    end
  end

  seq_mul_acc #(
    .WIDTH (WIDTH)
  ) u_acc (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (start),
    .en      (step),
    .k       (k),
    .lay_sum (lay_sum),
    .acc     (acc)
  );

  assign lay_cin = 1'b0;

  always_comb begin
    in_ready   = 1'b0;
    busy       = 1'b0;
    out_valid  = 1'b0;
    out_p      = '0;
    lay_a      = '0;
    lay_b_low  = 1'b0;
    lay_b_high = 1'b0;
    unique case (state)
      IDLE: in_ready = 1'b1;
      RUN: begin
        busy       = 1'b1;
        lay_a      = a_q;
        lay_b_low  = b_q[0];
        lay_b_high = b_q[1];
      end
      DONE: begin
        out_valid = 1'b1;
        out_p     = acc;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_seq_mul_signed16_ctrl.sv
// Randomized self-checking bench with an exact 16x2 layer model.
// Reference products come from plain signed multiplication.
module tb_seq_mul_signed16_ctrl;

  localparam int PAIRS = 8;
  localparam int LAT   = PAIRS;
  localparam int GAP   = PAIRS + 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_a = '0;
  logic [15:0] in_b = '0;
  logic [15:0] lay_a;
  logic        lay_b_low;
  logic        lay_b_high;
  logic        lay_cin;
  logic [17:0] lay_sum;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_p;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lay_k;
  int n_acc = 0;
  logic [31:0] exp_q[$];
  int acc_cyc[$];

  seq_mul_signed16_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .lay_a      (lay_a),
    .lay_b_low  (lay_b_low),
    .lay_b_high (lay_b_high),
    .lay_cin    (lay_cin),
    .lay_sum    (lay_sum),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_p      (out_p),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Exact layer: digit index follows the number of busy cycles so far
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) lay_k <= 0;
    else lay_k <= busy ? lay_k + 1 : 0;
  end

  always_comb begin
    int d;
    d = 2 * int'(lay_b_high) + int'(lay_b_low);
    if (lay_k == PAIRS - 1)
      d = -2 * int'(lay_b_high) + int'(lay_b_low);
    lay_sum = 18'(int'($signed(lay_a)) * d);
  end

  function automatic logic [31:0] ref_mul(logic [15:0] a, logic [15:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return p[31:0];
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_mul(in_a, in_b));
        acc_cyc.push_back(cyc);
        n_acc++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("spurious_out", 32'd1, 32'd0);
        else check("product", out_p, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(logic [15:0] a, logic [15:0] b);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) check("ready_timeout", 32'd0, 32'd1);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    if (n >= 40) check("valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_reset_outs(string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_p"}, out_p, 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_lay"}, {13'd0, lay_cin, lay_b_high, lay_b_low, lay_a},
          32'd0);
  endtask

  task automatic run_op(string tag, logic [15:0] a, logic [15:0] b,
                        logic [31:0] exp);
    int n;
    out_ready = 1'b1;
    send(a, b);
    wait_valid(n);
    check({tag, "_lat"}, 32'(n), 32'(LAT));
    check(tag, out_p, exp);
    tick();
  endtask

  initial begin
    int n;
    int hold;
    int base;
    int seen;
    logic [31:0] p0;
    logic [15:0] ra;
    logic [15:0] rb;

    #1;
    check_reset_outs("reset");
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    run_op("basic", 16'd3, 16'd5, 32'd15);
    check("basic_idle", 32'(in_ready), 32'd1);
    run_op("neg7x100", 16'hFFF9, 16'd100, 32'hFFFF_FD44);
    run_op("min_x_min", 16'h8000, 16'h8000, 32'h4000_0000);
    run_op("max_x_min", 16'h7FFF, 16'h8000, 32'hC000_8000);

    // Output backpressure
    out_ready = 1'b0;
    send(16'd1234, 16'hFDC9);
    wait_valid(n);
    p0 = out_p;
    check("bp_value", p0, ref_mul(16'd1234, 16'hFDC9));
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_stable", out_p, p0);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_ready", 32'(in_ready), 32'd1);

    // Back-to-back with in_valid held high
    base = n_acc;
    in_valid = 1'b1;
    in_a = 16'd321;
    in_b = 16'hFF00;
    n = 0;
    while (n_acc < base + 1 && n < 40) begin
      tick();
      n++;
    end
    in_a = 16'h8123;
    in_b = 16'd4567;
    n = 0;
    while (n_acc < base + 2 && n < 40) begin
      tick();
      n++;
    end
    in_valid = 1'b0;
    check("b2b_accepts", 32'(n_acc - base), 32'd2);
    if (acc_cyc.size() >= 2)
      check("b2b_gap", 32'(acc_cyc[$] - acc_cyc[$-1]), 32'(GAP));
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    check("b2b_drain", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of RUN
    send(16'd7, 16'd9);
    repeat (3) tick();
    check("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outs("midrst");
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid) seen++;
    end
    check("midrst_no_out", 32'(seen), 32'd0);
    run_op("after_rst", 16'd2, 16'd2, 32'd4);

    // Randomized operations with random output stalls
    for (int i = 0; i < 24; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i % 6 == 0) ra = 16'h8000;
      if (i % 7 == 1) rb = 16'hFFFF;
      out_ready = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
      send(ra, rb);
      wait_valid(n);
      check("rand_lat", 32'(n), 32'(LAT));
      check("rand_direct", out_p, ref_mul(ra, rb));
      hold = $urandom_range(0, 3);
      repeat (hold) tick();
      out_ready = 1'b1;
      tick();
    end

    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    check("final_drain", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
